// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between the fetch/data requesters, the SRAM and mem_arbiter
//
// Signal groups:
//   I_*        instruction fetch port (request/address in, grant/response out)
//   D_*        data port (request/address/we/size/wdata in, grant/response/error out)
//   M_*        single-port SRAM (M_DO in, all others out of the arbiter)
//   STALL_CNT  saturating count of fetch stall cycles
// Modports: slave = arbiter side, master = requesters/SRAM side.
interface mem_arbiter_if;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_GNT;
  logic        I_RVALID;
  logic [31:0] I_RDATA;

  logic        D_REQ;
  logic [31:0] D_ADDR;
  logic        D_WE;
  logic [1:0]  D_SIZE;
  logic [31:0] D_WDATA;
  logic        D_GNT;
  logic        D_RVALID;
  logic [31:0] D_RDATA;
  logic        D_ERR;

  logic        M_CSN;
  logic [11:0] M_ADDR;
  logic        M_WE;
  logic [3:0]  M_BE;
  logic [31:0] M_DI;
  logic [31:0] M_DO;

  logic [15:0] STALL_CNT;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_ADDR, D_WE, D_SIZE, D_WDATA, M_DO,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA, D_ERR,
    output M_CSN, M_ADDR, M_WE, M_BE, M_DI, STALL_CNT
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_ADDR, D_WE, D_SIZE, D_WDATA, M_DO,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA, D_ERR,
    input  M_CSN, M_ADDR, M_WE, M_BE, M_DI, STALL_CNT
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port SRAM
//
// Ports:
//   CLK    sole clock, rising edge
//   RESET  synchronous, active-high reset
//   bus    mem_arbiter_if.slave: fetch port, data port, SRAM port, STALL_CNT
// Grants are combinational; one access per cycle; read data returns one cycle
// after the grant, steered by a registered response tag.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
);

  localparam int SW = ($clog2(MAX_D_STREAK + 1) < 2) ? 2 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } tag_kind_e;

  tag_kind_e   tag_kind_q, tag_kind_d;
  logic [1:0]  tag_size_q, tag_size_d;
  logic [1:0]  tag_off_q, tag_off_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [15:0] stall_q, stall_d;

  logic        d_ill;
  logic        i_win;
  logic        i_gnt;
  logic        d_gnt;
  logic        d_go;
  logic [3:0]  d_be;
  logic [31:0] d_di;
  logic [31:0] d_shifted;
  logic        i_rvalid;
  logic        d_rvalid;

  // Request decode and grant.
  always_comb begin
    d_ill = (bus.D_SIZE == 2'b11)
          | ((bus.D_SIZE == 2'b01) & bus.D_ADDR[0])
          | ((bus.D_SIZE == 2'b10) & (bus.D_ADDR[1:0] != 2'b00));
    // Fetch wins only when data is idle or data has used up its streak.
    i_win = bus.I_REQ & (~bus.D_REQ | (streak_q == STREAK_MAX));
    i_gnt = ~RESET & i_win;
    d_gnt = ~RESET & bus.D_REQ & ~i_win;
    // An illegal data request is accepted (and flagged) but never reaches SRAM.
    d_go  = d_gnt & ~d_ill;
  end

  // Data-side byte enables and lane-replicated write data.
  always_comb begin
    d_be = 4'b1111;
    d_di = bus.D_WDATA;
    case (bus.D_SIZE)
      2'b00: begin
        d_be = 4'b0001 << bus.D_ADDR[1:0];
        d_di = {4{bus.D_WDATA[7:0]}};
      end
      2'b01: begin
        d_be = bus.D_ADDR[1] ? 4'b1100 : 4'b0011;
        d_di = {2{bus.D_WDATA[15:0]}};
      end
      default: begin
        d_be = 4'b1111;
        d_di = bus.D_WDATA;
      end
    endcase
  end

  // SRAM port: idle values unless an access actually issues.
  always_comb begin
    bus.M_CSN  = 1'b1;
    bus.M_ADDR = 12'h000;
    bus.M_WE   = 1'b0;
    bus.M_BE   = 4'b0000;
    bus.M_DI   = 32'h0000_0000;
    if (i_gnt) begin
      bus.M_CSN  = 1'b0;
      bus.M_ADDR = bus.I_ADDR[13:2];
      bus.M_BE   = 4'b1111;
    end else if (d_go) begin
      bus.M_CSN  = 1'b0;
      bus.M_ADDR = bus.D_ADDR[13:2];
      bus.M_WE   = bus.D_WE;
      bus.M_BE   = d_be;
      if (bus.D_WE) begin
        bus.M_DI = d_di;
      end
    end
  end

  // Grant/error outputs.
  always_comb begin
    bus.I_GNT     = i_gnt;
    bus.D_GNT     = d_gnt;
    bus.D_ERR     = d_gnt & d_ill;
    bus.STALL_CNT = stall_q;
  end

  // Read response, steered by the tag captured at the grant edge. RESET masks
  // a response already in flight so a read granted just before reset is dropped.
  always_comb begin
    i_rvalid     = ~RESET & (tag_kind_q == TAG_I);
    d_rvalid     = ~RESET & (tag_kind_q == TAG_D);
    d_shifted    = bus.M_DO >> {tag_off_q, 3'b000};
    bus.I_RVALID = i_rvalid;
    bus.D_RVALID = d_rvalid;
    bus.I_RDATA  = 32'h0000_0000;
    bus.D_RDATA  = 32'h0000_0000;
    if (i_rvalid) begin
      bus.I_RDATA = bus.M_DO;
    end
    if (d_rvalid) begin
      case (tag_size_q)
        2'b00:   bus.D_RDATA = {24'h000000, d_shifted[7:0]};
        2'b01:   bus.D_RDATA = {16'h0000, d_shifted[15:0]};
        default: bus.D_RDATA = d_shifted;
      endcase
    end
  end

  // Next-state: streak, stall counter, response tag.
  always_comb begin
    streak_d   = streak_q;
    stall_d    = stall_q;
    tag_kind_d = TAG_NONE;
    tag_size_d = 2'b00;
    tag_off_d  = 2'b00;

    if (!bus.I_REQ || i_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end

    if (bus.I_REQ && !i_gnt && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end

    if (i_gnt) begin
      tag_kind_d = TAG_I;
    end else if (d_go && !bus.D_WE) begin
      tag_kind_d = TAG_D;
      tag_size_d = bus.D_SIZE;
      tag_off_d  = bus.D_ADDR[1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      streak_q   <= '0;
      stall_q    <= 16'h0000;
      tag_kind_q <= TAG_NONE;
      tag_size_q <= 2'b00;
      tag_off_q  <= 2'b00;
    end else begin
      streak_q   <= streak_d;
      stall_q    <= stall_d;
      tag_kind_q <= tag_kind_d;
      tag_size_q <= tag_size_d;
      tag_off_q  <= tag_off_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic CLK;
  logic RESET;
  int   vectors;
  int   miscompares;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_D_STREAK(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET       = 1'b1;
    bus.I_REQ   = 1'b1;
    bus.I_ADDR  = 32'h10;
    bus.D_REQ   = 1'b1;
    bus.D_ADDR  = 32'h0;
    bus.D_WE    = 1'b0;
    bus.D_SIZE  = 2'b10;
    bus.D_WDATA = 32'h0;
    bus.M_DO    = 32'h1122_3344;

    // Reset with requests pending: nothing may be granted or issued.
    cyc();
    smp();
    chk("rst_i_gnt", {31'b0, bus.I_GNT}, 32'd0);
    chk("rst_d_gnt", {31'b0, bus.D_GNT}, 32'd0);
    chk("rst_csn", {31'b0, bus.M_CSN}, 32'd1);
    chk("rst_d_err", {31'b0, bus.D_ERR}, 32'd0);
    chk("rst_i_rvalid", {31'b0, bus.I_RVALID}, 32'd0);
    chk("rst_d_rvalid", {31'b0, bus.D_RVALID}, 32'd0);
    chk("rst_stall", {16'b0, bus.STALL_CNT}, 32'd0);

    // Fetch only.
    cyc();
    RESET     = 1'b0;
    bus.D_REQ = 1'b0;
    smp();
    chk("fetch_gnt", {31'b0, bus.I_GNT}, 32'd1);
    chk("fetch_maddr", {20'b0, bus.M_ADDR}, 32'h004);
    chk("fetch_be", {28'b0, bus.M_BE}, 32'hF);
    chk("fetch_csn", {31'b0, bus.M_CSN}, 32'd0);
    chk("fetch_we", {31'b0, bus.M_WE}, 32'd0);
    cyc();
    bus.I_REQ = 1'b0;
    smp();
    chk("fetch_rvalid", {31'b0, bus.I_RVALID}, 32'd1);
    chk("fetch_rdata", bus.I_RDATA, 32'h1122_3344);
    chk("idle_csn", {31'b0, bus.M_CSN}, 32'd1);
    chk("idle_be", {28'b0, bus.M_BE}, 32'h0);
    chk("idle_maddr", {20'b0, bus.M_ADDR}, 32'h0);
    chk("fetch_stall", {16'b0, bus.STALL_CNT}, 32'd0);

    // Byte load at offset 3.
    cyc();
    bus.D_REQ  = 1'b1;
    bus.D_ADDR = 32'h103;
    bus.D_SIZE = 2'b00;
    bus.D_WE   = 1'b0;
    bus.M_DO   = 32'hAABB_CCDD;
    smp();
    chk("lb_gnt", {31'b0, bus.D_GNT}, 32'd1);
    chk("lb_be", {28'b0, bus.M_BE}, 32'h8);
    chk("lb_maddr", {20'b0, bus.M_ADDR}, 32'h040);
    cyc();
    bus.D_REQ = 1'b0;
    smp();
    chk("lb_rvalid", {31'b0, bus.D_RVALID}, 32'd1);
    chk("lb_rdata", bus.D_RDATA, 32'h0000_00AA);

    // Halfword store at offset 2.
    cyc();
    bus.D_REQ   = 1'b1;
    bus.D_ADDR  = 32'h22;
    bus.D_SIZE  = 2'b01;
    bus.D_WE    = 1'b1;
    bus.D_WDATA = 32'h1234_ABCD;
    smp();
    chk("sh_we", {31'b0, bus.M_WE}, 32'd1);
    chk("sh_be", {28'b0, bus.M_BE}, 32'hC);
    chk("sh_di", bus.M_DI, 32'hABCD_ABCD);
    chk("sh_maddr", {20'b0, bus.M_ADDR}, 32'h008);
    cyc();
    bus.D_REQ = 1'b0;
    smp();
    chk("sh_no_rvalid", {31'b0, bus.D_RVALID}, 32'd0);

    // Byte store at offset 1.
    cyc();
    bus.D_REQ   = 1'b1;
    bus.D_ADDR  = 32'h1;
    bus.D_SIZE  = 2'b00;
    bus.D_WE    = 1'b1;
    bus.D_WDATA = 32'h0000_005A;
    smp();
    chk("sb_be", {28'b0, bus.M_BE}, 32'h2);
    chk("sb_di", bus.M_DI, 32'h5A5A_5A5A);

    // Halfword load, upper half.
    cyc();
    bus.D_ADDR = 32'h22;
    bus.D_SIZE = 2'b01;
    bus.D_WE   = 1'b0;
    smp();
    chk("lh_be", {28'b0, bus.M_BE}, 32'hC);
    cyc();
    bus.D_REQ = 1'b0;
    smp();
    chk("lh_rdata", bus.D_RDATA, 32'h0000_AABB);

    // Misaligned word.
    cyc();
    bus.D_REQ  = 1'b1;
    bus.D_ADDR = 32'h06;
    bus.D_SIZE = 2'b10;
    smp();
    chk("mis_gnt", {31'b0, bus.D_GNT}, 32'd1);
    chk("mis_err", {31'b0, bus.D_ERR}, 32'd1);
    chk("mis_csn", {31'b0, bus.M_CSN}, 32'd1);
    cyc();
    bus.D_ADDR = 32'h0;
    bus.D_SIZE = 2'b11;
    smp();
    chk("mis_no_rvalid", {31'b0, bus.D_RVALID}, 32'd0);
    chk("size11_err", {31'b0, bus.D_ERR}, 32'd1);
    chk("size11_csn", {31'b0, bus.M_CSN}, 32'd1);
    cyc();
    bus.D_REQ = 1'b0;
    smp();
    chk("size11_no_rvalid", {31'b0, bus.D_RVALID}, 32'd0);
    chk("err_cleared", {31'b0, bus.D_ERR}, 32'd0);

    // Contention: expect D,D,D,I,D,D,D,I.
    cyc();
    bus.I_REQ  = 1'b1;
    bus.I_ADDR = 32'h10;
    bus.D_REQ  = 1'b1;
    bus.D_ADDR = 32'h0;
    bus.D_SIZE = 2'b10;
    bus.D_WE   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk($sformatf("cont_i_gnt_%0d", k), {31'b0, bus.I_GNT}, (k == 3 || k == 7) ? 32'd1 : 32'd0);
      chk($sformatf("cont_d_gnt_%0d", k), {31'b0, bus.D_GNT}, (k == 3 || k == 7) ? 32'd0 : 32'd1);
      cyc();
    end
    bus.I_REQ = 1'b0;
    bus.D_REQ = 1'b0;
    smp();
    chk("cont_stall", {16'b0, bus.STALL_CNT}, 32'd6);

    // Reset mid-read.
    cyc();
    bus.D_REQ  = 1'b1;
    bus.D_ADDR = 32'h0;
    bus.D_SIZE = 2'b10;
    smp();
    chk("rmr_gnt", {31'b0, bus.D_GNT}, 32'd1);
    cyc();
    RESET     = 1'b1;
    bus.D_REQ = 1'b0;
    smp();
    chk("rmr_rvalid", {31'b0, bus.D_RVALID}, 32'd0);
    cyc();
    smp();
    chk("rmr_rvalid2", {31'b0, bus.D_RVALID}, 32'd0);
    chk("rmr_stall", {16'b0, bus.STALL_CNT}, 32'd0);
    cyc();
    RESET = 1'b0;
    smp();
    chk("post_rst_rvalid", {31'b0, bus.D_RVALID}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_D_STREAK, default 3: the maximum number of consecutive data grants while I_REQ waits.
REQ-002 The block SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port I_REQ  input  1  instruction fetch request, held until granted.
REQ-005 The block SHALL have port I_ADDR  input  32  fetch byte address; bits [13:2] are used.
REQ-006 The block SHALL have port I_GNT  output  1  fetch accepted this cycle.
REQ-007 The block SHALL have port I_RVALID  output  1  fetch data valid.
REQ-008 The block SHALL have port I_RDATA  output  32  raw fetched word.
REQ-009 The block SHALL have port D_REQ  input  1  data request, held until granted.
REQ-010 The block SHALL have port D_ADDR  input  32  data byte address.
REQ-011 The block SHALL have port D_WE  input  1  1 = store, 0 = load.
REQ-012 The block SHALL have port D_SIZE  input  2  00 byte, 01 halfword, 10 word.
REQ-013 The block SHALL have port D_WDATA  input  32  store data, right-aligned.
REQ-014 The block SHALL have port D_GNT  output  1  data access accepted this cycle.
REQ-015 The block SHALL have port D_RVALID  output  1  load data valid.
REQ-016 The block SHALL have port D_RDATA  output  32  load data, right-aligned and zero-extended.
REQ-017 The block SHALL have port D_ERR  output  1  one-cycle pulse flagging a misaligned or illegal-size data request.
REQ-018 The block SHALL have port M_CSN  output  1  single-port SRAM chip select, active low.
REQ-019 The block SHALL have port M_ADDR  output  12  SRAM word address.
REQ-020 The block SHALL have port M_WE  output  1  SRAM write enable.
REQ-021 The block SHALL have port M_BE  output  4  SRAM byte enables.
REQ-022 The block SHALL have port M_DI  output  32  SRAM write data.
REQ-023 The block SHALL have port M_DO  input  32  SRAM read data, valid one cycle after CSN low with WE low.
REQ-024 The block SHALL have port STALL_CNT  output  16  saturating count of cycles in which I_REQ was high and I_GNT low.

Function
REQ-025 The block SHALL decide grants combinationally from the requests and registered state; at most one of I_GNT and D_GNT is high in any cycle.
REQ-026 The block SHALL grant D_REQ over I_REQ unless I_REQ=1 and streak=MAX_D_STREAK; in that case I_GNT=1.
REQ-027 The block SHALL increment the 2-bit-or-wider streak counter on each D_GNT while I_REQ=1, and clear it on I_GNT or whenever I_REQ=0.
REQ-028 The block SHALL treat a data request as illegal when D_SIZE=11, or halfword with D_ADDR[0]=1, or word with D_ADDR[1:0]!=00.
REQ-029 For an illegal request, the block SHALL assert D_GNT and D_ERR in the same cycle, hold M_CSN=1, and produce no D_RVALID.
REQ-030 In a granted cycle, the block SHALL drive M_CSN=0 and M_ADDR=ADDR[13:2] of the winner; M_WE=D_WE for data and 0 for fetch.
REQ-031 M_BE SHALL be 1111 for fetches; for data, byte gives 0001<<ADDR[1:0], halfword gives 0011 or 1100 by ADDR[1], and word gives 1111.
REQ-032 M_DI SHALL carry the store byte replicated into all 4 lanes, a halfword replicated into 2 lanes, or a word unchanged.
REQ-033 When no access is granted, the block SHALL drive M_CSN=1, M_WE=0, M_BE=0000, and M_ADDR=0.
REQ-034 The read response SHALL follow grant by exactly 1 cycle: a registered tag (none/I/D plus size and offset) is captured at the grant edge.
REQ-035 Back-to-back grants SHALL be allowed every cycle, giving a throughput of 1 access per cycle.
REQ-036 I_RDATA SHALL equal M_DO while I_RVALID is high.
REQ-037 D_RDATA SHALL be M_DO shifted right by 8*offset and masked to the size while D_RVALID is high; RDATA SHALL be 0 when RVALID is low.
REQ-038 Stores SHALL complete at grant and SHALL produce no RVALID.
REQ-039 STALL_CNT SHALL saturate at FFFF and never wrap.

Reset
REQ-040 While RESET=1, at the clock edge the block SHALL clear the streak, the response tag, and STALL_CNT.
REQ-041 While RESET=1, all GNT, RVALID, and D_ERR outputs SHALL be 0, M_CSN SHALL be 1, and no SRAM access SHALL issue, whatever the request inputs.
REQ-042 A read granted in the cycle before RESET rises SHALL NOT produce RVALID.

Verification
REQ-043 Fetch only: I_REQ=1, I_ADDR=0x10 -> same cycle I_GNT=1, M_ADDR=0x004, M_BE=1111; next cycle I_RVALID=1, I_RDATA=M_DO.
REQ-044 Byte load: D_ADDR=0x103, size 00, M_DO=0xAABBCCDD -> M_BE=1000; next cycle D_RDATA=0x000000AA.
REQ-045 Halfword store: D_ADDR=0x22, D_WDATA=0x1234ABCD -> M_WE=1, M_BE=1100, M_DI=0xABCDABCD, no D_RVALID.
REQ-046 Contention with I_REQ and D_REQ held high 8 cycles -> grant pattern D,D,D,I,D,D,D,I; STALL_CNT=6.
REQ-047 Misaligned word: D_ADDR=0x06, size 10 -> D_GNT=1, D_ERR=1, M_CSN=1, no D_RVALID.
REQ-048 Reset mid-read: load granted, then RESET=1 the next edge -> D_RVALID stays 0 and STALL_CNT=0.
